uart_rx_shift_register: RTL and testbench

Serial receive front end of the UART RX path, directly upstream of the RX control FSM. It synchronises the RXD line, oversamples it against the baud tick, and shifts in one frame: start, 5–8 data bits LSB first, optional parity, one or two stops. It returns per-field status flags (start_bit, data_is_received, parity_bit, stop_bit) to the FSM and presents the assembled data word to the RX buffer.

---
 rtl/uart_rx_shift_register.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_rx_shift_register.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_shift_register.sv
// UART receive front end: RXD synchroniser, oversampling sequencer,
// data/parity/stop shifter with sticky per-field status flags.
module uart_rx_shift_register #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_MAX    = 8
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                baud_tick,
  input  logic                rxd,
  input  logic [3:0]          ctrl_shift_register,
  input  logic [3:0]          number_data_receive,
  input  logic                parity_bit_mode,
  input  logic                parity_odd,
  input  logic                stop_bit_twice,
  output logic                start_bit,
  output logic                data_is_received,
  output logic                parity_bit,
  output logic                stop_bit,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                frame_error,
  output logic                parity_error
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);

  typedef enum logic [2:0] {
    SEQ_IDLE,
    HUNT,
    START,
    DATA,
    PARITY,
    STOP0,
    STOP1
  } seq_t;

  seq_t state_q, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   prev_q, prev_n;
  logic [CW-1:0]          cnt_q, cnt_n, cur;
  logic                   smp;

  logic [3:0]             n_q, n_n, n_cfg;
  logic                   pen_q, pen_n;
  logic                   podd_q, podd_n;
  logic                   two_q, two_n;

  logic [3:0]             bit_q, bit_n;
  logic [DATA_MAX-1:0]    sh_q, sh_n, sh_ins;
  logic                   acc_q, acc_n;

  logic                   st_q, st_n;
  logic                   dr_q, dr_n;
  logic                   pb_q, pb_n;
  logic                   sp_q, sp_n;
  logic [DATA_MAX-1:0]    rd_q, rd_n;
  logic                   fe_q, fe_n;
  logic                   pe_q, pe_n;

  logic                   abort;
  logic                   arm;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rx_s  = sync_q[SYNC_STAGES-1];
  assign abort = (ctrl_shift_register == 4'b0000);
  assign arm   = (ctrl_shift_register == 4'b0001);
  assign cur   = cnt_q + 1'b1;
  assign smp   = baud_tick && (cur == HALF);

  always_comb begin
    if (number_data_receive <= 4'd5) begin
      n_cfg = 4'd5;
    end else if (number_data_receive >= 4'd8) begin
      n_cfg = 4'd8;
    end else begin
      n_cfg = number_data_receive;
    end
  end

  always_comb begin
    for (int i = 0; i < DATA_MAX; i++) begin
      sh_ins[i] = (i == int'(bit_q)) ? rx_s : sh_q[i];
    end
  end

  always_comb begin
    state_n = state_q;
    prev_n  = prev_q;
    cnt_n   = cnt_q;
    n_n     = n_q;
    pen_n   = pen_q;
    podd_n  = podd_q;
    two_n   = two_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    acc_n   = acc_q;
    st_n    = st_q;
    dr_n    = dr_q;
    pb_n    = pb_q;
    sp_n    = sp_q;
    rd_n    = rd_q;
    fe_n    = fe_q;
    pe_n    = pe_q;

    if (baud_tick) begin
      prev_n = rx_s;
    end

    if (abort && state_q != SEQ_IDLE) begin
      // rx_data survives an abort; only the frame in flight is dropped
      state_n = SEQ_IDLE;
      sh_n    = '0;
      st_n    = 1'b0;
      dr_n    = 1'b0;
      pb_n    = 1'b0;
      sp_n    = 1'b0;
      fe_n    = 1'b0;
      pe_n    = 1'b0;
    end else begin
      if (baud_tick) begin
        cnt_n = cur;
      end
      unique case (state_q)
        SEQ_IDLE: begin
          if (arm) begin
            state_n = HUNT;
            sh_n    = '0;
            st_n    = 1'b0;
            dr_n    = 1'b0;
            pb_n    = 1'b0;
            sp_n    = 1'b0;
            rd_n    = '0;
            fe_n    = 1'b0;
            pe_n    = 1'b0;
          end
        end
        HUNT: begin
          if (baud_tick && !rx_s && prev_q) begin
            state_n = START;
            cnt_n   = '0;
            n_n     = n_cfg;
            pen_n   = parity_bit_mode;
            podd_n  = parity_odd;
            two_n   = stop_bit_twice;
            bit_n   = '0;
            sh_n    = '0;
            acc_n   = 1'b0;
          end
        end
        START: begin
          if (smp) begin
            if (!rx_s) begin
              st_n    = 1'b1;
              state_n = DATA;
            end else begin
              state_n = HUNT;
            end
          end
        end
        DATA: begin
          if (smp) begin
            sh_n  = sh_ins;
            acc_n = acc_q ^ rx_s;
            bit_n = bit_q + 4'd1;
            if (bit_q == n_q - 4'd1) begin
              rd_n = sh_ins;
              dr_n = 1'b1;
              if (pen_q) begin
                state_n = PARITY;
              end else begin
                pb_n    = 1'b1;
                state_n = STOP0;
              end
            end
          end
        end
        PARITY: begin
          if (smp) begin
            if ((acc_q ^ rx_s) == podd_q) begin
              pb_n = 1'b1;
            end else begin
              pe_n = 1'b1;
              pb_n = 1'b0;
            end
            state_n = STOP0;
          end
        end
        STOP0: begin
          if (smp) begin
            if (!rx_s) begin
              fe_n    = 1'b1;
              sp_n    = 1'b0;
              state_n = SEQ_IDLE;
            end else if (two_q) begin
              state_n = STOP1;
            end else begin
              sp_n    = 1'b1;
              state_n = SEQ_IDLE;
            end
          end
        end
        STOP1: begin
          if (smp) begin
            if (rx_s) begin
              sp_n = 1'b1;
            end else begin
              fe_n = 1'b1;
            end
            state_n = SEQ_IDLE;
          end
        end
        default: state_n = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= SEQ_IDLE;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      n_q     <= 4'd8;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      two_q   <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      st_q    <= 1'b0;
      dr_q    <= 1'b0;
      pb_q    <= 1'b0;
      sp_q    <= 1'b0;
      rd_q    <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      prev_q  <= prev_n;
      cnt_q   <= cnt_n;
      n_q     <= n_n;
      pen_q   <= pen_n;
      podd_q  <= podd_n;
      two_q   <= two_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      acc_q   <= acc_n;
      st_q    <= st_n;
      dr_q    <= dr_n;
      pb_q    <= pb_n;
      sp_q    <= sp_n;
      rd_q    <= rd_n;
      fe_q    <= fe_n;
      pe_q    <= pe_n;
    end
  end

  assign start_bit        = st_q;
  assign data_is_received = dr_q;
  assign parity_bit       = pb_q;
  assign stop_bit         = sp_q;
  assign rx_data          = rd_q;
  assign frame_error      = fe_q;
  assign parity_error     = pe_q;

endmodule

// File: tb/tb_uart_rx_shift_register.sv
// Directed bench for uart_rx_shift_register: frames driven one bit
// per 16 PCLK with baud_tick held high.
module tb_uart_rx_shift_register;

  logic       PCLK;
  logic       PRESETn;
  logic       baud_tick;
  logic       rxd;
  logic [3:0] ctrl;
  logic [3:0] ndr;
  logic       pm;
  logic       po;
  logic       st2;
  logic       start_bit;
  logic       data_is_received;
  logic       parity_bit;
  logic       stop_bit;
  logic [7:0] rx_data;
  logic       frame_error;
  logic       parity_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] fbits;
  int          flen;
  int          pos;

  uart_rx_shift_register #(
    .OVERSAMPLE(16),
    .SYNC_STAGES(2),
    .DATA_MAX(8)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .baud_tick(baud_tick),
    .rxd(rxd),
    .ctrl_shift_register(ctrl),
    .number_data_receive(ndr),
    .parity_bit_mode(pm),
    .parity_odd(po),
    .stop_bit_twice(st2),
    .start_bit(start_bit),
    .data_is_received(data_is_received),
    .parity_bit(parity_bit),
    .stop_bit(stop_bit),
    .rx_data(rx_data),
    .frame_error(frame_error),
    .parity_error(parity_error)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] d, input int n,
                      input bit pen, input logic pv,
                      input int nstop, input logic sv);
    int idx;
    fbits = '1;
    fbits[0] = 1'b0;
    for (int i = 0; i < n; i++) fbits[1+i] = d[i];
    idx = 1 + n;
    if (pen) begin
      fbits[idx] = pv;
      idx++;
    end
    for (int s = 0; s < nstop; s++) begin
      fbits[idx] = sv;
      idx++;
    end
    flen = idx;
    pos  = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      rxd = (pos < flen * 16) ? fbits[pos/16] : 1'b1;
      pos++;
    end
  endtask

  task automatic arm();
    @(negedge PCLK);
    ctrl = 4'b0001;
    @(negedge PCLK);
    ctrl = 4'b0010;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, 32'(start_bit), 0);
    chk({tag, "_dr"}, 32'(data_is_received), 0);
    chk({tag, "_pb"}, 32'(parity_bit), 0);
    chk({tag, "_stop"}, 32'(stop_bit), 0);
    chk({tag, "_rx"}, 32'(rx_data), 0);
    chk({tag, "_fe"}, 32'(frame_error), 0);
    chk({tag, "_pe"}, 32'(parity_error), 0);
  endtask

  initial begin
    PRESETn   = 1'b0;
    baud_tick = 1'b1;
    rxd       = 1'b1;
    ctrl      = 4'b0000;
    ndr       = 4'd8;
    pm        = 1'b0;
    po        = 1'b0;
    st2       = 1'b0;
    flen      = 0;
    pos       = 0;
    fbits     = '1;
    repeat (3) @(negedge PCLK);
    chk_zero("reset");
    PRESETn = 1'b1;
    ctrl    = 4'b0010;
    repeat (4) @(negedge PCLK);

    // 8N1 0xA5 with cycle-accurate flag timing
    arm();
    load(8'hA5, 8, 0, 1'b0, 1, 1'b1);
    steps(11);
    chk("a5_start_pre", 32'(start_bit), 0);
    steps(1);
    chk("a5_start_t8", 32'(start_bit), 1);
    steps(127);
    chk("a5_dr_pre", 32'(data_is_received), 0);
    steps(1);
    chk("a5_dr_t136", 32'(data_is_received), 1);
    chk("a5_rx", 32'(rx_data), 32'hA5);
    chk("a5_pb", 32'(parity_bit), 1);
    steps(15);
    chk("a5_stop_pre", 32'(stop_bit), 0);
    steps(1);
    chk("a5_stop_t152", 32'(stop_bit), 1);
    chk("a5_fe", 32'(frame_error), 0);
    chk("a5_pe", 32'(parity_error), 0);
    steps(14);

    // 7E1 0x35, good then bad parity
    ndr = 4'd7;
    pm  = 1'b1;
    arm();
    load(8'h35, 7, 1, 1'b0, 1, 1'b1);
    steps(170);
    chk("e7_rx", 32'(rx_data), 32'h35);
    chk("e7_pb", 32'(parity_bit), 1);
    chk("e7_pe", 32'(parity_error), 0);
    chk("e7_stop", 32'(stop_bit), 1);
    arm();
    load(8'h35, 7, 1, 1'b1, 1, 1'b1);
    steps(170);
    chk("e7b_rx", 32'(rx_data), 32'h35);
    chk("e7b_pb", 32'(parity_bit), 0);
    chk("e7b_pe", 32'(parity_error), 1);
    chk("e7b_stop", 32'(stop_bit), 1);

    // 5O2 0x1F, N=3 clamps to 5, config changed mid-frame
    ndr = 4'd3;
    pm  = 1'b1;
    po  = 1'b1;
    st2 = 1'b1;
    arm();
    load(8'h1F, 5, 1, 1'b0, 2, 1'b1);
    steps(20);
    ndr = 4'd8;
    pm  = 1'b0;
    po  = 1'b0;
    st2 = 1'b0;
    steps(104);
    chk("o5_stop_first", 32'(stop_bit), 0);
    chk("o5_fe_first", 32'(frame_error), 0);
    chk("o5_rx", 32'(rx_data), 32'h1F);
    steps(16);
    chk("o5_stop_second", 32'(stop_bit), 1);
    chk("o5_pb", 32'(parity_bit), 1);
    chk("o5_pe", 32'(parity_error), 0);
    chk("o5_fe", 32'(frame_error), 0);
    steps(10);

    // 8N1 with low stop, N=15 clamps to 8
    ndr = 4'd15;
    arm();
    load(8'h5A, 8, 0, 1'b0, 1, 1'b0);
    steps(170);
    chk("fe_fe", 32'(frame_error), 1);
    chk("fe_stop", 32'(stop_bit), 0);
    chk("fe_rx", 32'(rx_data), 32'h5A);
    chk("fe_dr", 32'(data_is_received), 1);
    arm();
    chk_zero("rearm");

    // glitch in HUNT, then a real frame
    ndr = 4'd8;
    repeat (6) begin
      @(negedge PCLK);
      rxd = 1'b0;
    end
    @(negedge PCLK);
    rxd = 1'b1;
    repeat (30) @(negedge PCLK);
    chk("gl_start", 32'(start_bit), 0);
    load(8'h3C, 8, 0, 1'b0, 1, 1'b1);
    steps(170);
    chk("gl_rx", 32'(rx_data), 32'h3C);
    chk("gl_start2", 32'(start_bit), 1);
    chk("gl_stop", 32'(stop_bit), 1);
    chk("gl_fe", 32'(frame_error), 0);

    // abort after three data bits
    arm();
    load(8'h96, 8, 0, 1'b0, 1, 1'b1);
    steps(64);
    chk("ab_start_pre", 32'(start_bit), 1);
    chk("ab_dr_pre", 32'(data_is_received), 0);
    ctrl = 4'b0000;
    steps(1);
    chk("ab_start", 32'(start_bit), 0);
    chk("ab_dr", 32'(data_is_received), 0);
    chk("ab_rx", 32'(rx_data), 0);
    ctrl = 4'b0010;
    steps(105);
    chk("ab_dr_end", 32'(data_is_received), 0);
    chk("ab_stop_end", 32'(stop_bit), 0);

    // async reset mid-frame
    pm = 1'b1;
    arm();
    load(8'hC3, 8, 1, 1'b0, 1, 1'b1);
    steps(140);
    chk("rs_dr_pre", 32'(data_is_received), 1);
    chk("rs_rx_pre", 32'(rx_data), 32'hC3);
    #2;
    PRESETn = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge PCLK);
    PRESETn = 1'b1;
    steps(30);
    chk("rs_start_after", 32'(start_bit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
